// File: rtl/lsu_pkg.sv
// +----------------------------------------------------------------------+
// | lsu_pkg -- funct3 codes, FSM states and request legality check.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package lsu_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  // Stores share the size codes of the signed loads.
  localparam funct3_e F3_SB = F3_LB;
  localparam funct3_e F3_SH = F3_LH;
  localparam funct3_e F3_SW = F3_LW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic lsu_illegal(input logic we, input logic [2:0] f3,
                                       input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = off[0];
      F3_LW:   bad = (off != 2'b00);
      F3_LBU:  bad = we;
      F3_LHU:  bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// +----------------------------------------------------------------------+
// | lsu_lane_align -- load lane extract/extend and store lane merge.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  bit_off;

  always_comb begin
    bit_off  = {byte_off, 3'b000};
    byte_sel = rd_word[bit_off +: 8];
    half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data  = '0;
    st_word  = rd_word;
    case (funct3)
      F3_LB: begin
        ld_data = {{24{byte_sel[7]}}, byte_sel};
        st_word[bit_off +: 8] = st_data[7:0];
      end
      F3_LH: begin
        ld_data = {{16{half_sel[15]}}, half_sel};
        if (byte_off[1]) st_word[31:16] = st_data[15:0];
        else             st_word[15:0]  = st_data[15:0];
      end
      F3_LW: begin
        ld_data = rd_word;
        st_word = st_data;
      end
      F3_LBU:  ld_data = {24'h0, byte_sel};
      F3_LHU:  ld_data = {16'h0, half_sel};
      default: ld_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// +----------------------------------------------------------------------+
// | load_store_unit -- single-request RV32I load/store FSM to word RAM.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int L = 128,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [W-1:0]         req_wdata,
  output logic                 resp_valid,
  output logic [W-1:0]         resp_rdata,
  output logic                 resp_err,
  output logic [$clog2(L)-1:0] mem_addr,
  output logic                 mem_wr_ena,
  output logic [W-1:0]         mem_wr_data,
  input  logic [W-1:0]         mem_rd_data
);

  localparam int AW = $clog2(L);

  state_e         state_q, state_d;
  logic           we_q, we_d;
  logic [2:0]     funct3_q, funct3_d;
  logic [AW+1:0]  addr_q, addr_d;
  logic [W-1:0]   wdata_q, wdata_d;
  logic [W-1:0]   rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           req_err;
  logic [W-1:0]   ld_data;
  logic [W-1:0]   st_word;

  // Range error: any address bit beyond the RAM byte span.
  always_comb begin
    req_err = lsu_illegal(req_we, req_funct3, req_addr[1:0])
              || (req_addr[31:AW+2] != '0);
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr[AW+1:0];
          wdata_d  = req_wdata;
          err_d    = req_err;
          state_d  = req_err ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        rdata_d = mem_rd_data;
        state_d = we_q ? ST_WRITE : ST_DONE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  lsu_lane_align u_align (
    .funct3   (funct3_q),
    .byte_off (addr_q[1:0]),
    .rd_word  (rdata_q),
    .st_data  (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    resp_valid  = (state_q == ST_DONE);
    resp_err    = (state_q == ST_DONE) && err_q;
    resp_rdata  = ((state_q == ST_DONE) && !err_q && !we_q) ? ld_data : '0;
    mem_addr    = (state_q == ST_IDLE) ? '0 : addr_q[AW+1:2];
    mem_wr_ena  = (state_q == ST_WRITE);
    mem_wr_data = (state_q == ST_WRITE) ? st_word : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// +----------------------------------------------------------------------+
// | tb_load_store_unit -- directed self-checking bench for the LSU.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [6:0]  mem_addr;
  logic        mem_wr_ena;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  logic [31:0] ram [128];
  int          n_checks;
  int          n_errors;

  load_store_unit #(.L(128), .W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .mem_addr    (mem_addr),
    .mem_wr_ena  (mem_wr_ena),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = ram[mem_addr];

  initial begin
    for (int i = 0; i < 128; i++) ram[i] = 32'h1000_0000 + i;
    ram[4] = 32'h8899_AABB;
    forever begin
      @(posedge clk);
      if (mem_wr_ena) ram[mem_addr] <= mem_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic err,
                         output logic [31:0] rdata, output int wr_n, output int wr_cyc,
                         output logic [31:0] wr_data, output logic [31:0] idx);
    int  n;
    bit  got;
    lat = 0; err = 1'b0; rdata = '0; wr_n = 0; wr_cyc = 0; wr_data = '0; idx = '0;
    got = 1'b0; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = 32'hA5A5_A5A5;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) idx = 32'(mem_addr);
      if (mem_wr_ena) begin
        wr_n++;
        wr_cyc = c;
        wr_data = mem_wr_data;
      end
      if (resp_valid && !got) begin
        got = 1'b1;
        lat = c;
        err = resp_err;
        rdata = resp_rdata;
      end
    end
  endtask

  task automatic chk_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] exp);
    int lat, wn, wc;
    logic e;
    logic [31:0] rd, wd, ix;
    run_req(1'b0, f3, addr, 32'h0, lat, e, rd, wn, wc, wd, ix);
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_err"}, 32'(e), 32'd0);
    chk({tag, "_data"}, rd, exp);
  endtask

  task automatic chk_err(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int lat, wn, wc;
    logic e;
    logic [31:0] rd, wd, ix;
    run_req(we, f3, addr, wdata, lat, e, rd, wn, wc, wd, ix);
    chk({tag, "_lat"}, 32'(lat), 32'd1);
    chk({tag, "_err"}, 32'(e), 32'd1);
    chk({tag, "_rdata"}, rd, 32'h0);
    chk({tag, "_nowr"}, 32'(wn), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, wn, wc, n, seen, ready_at, r1, r2;
    logic e;
    logic [31:0] rd, wd, ix, d2, bwd;
    int bwc;

    n_checks = 0; n_errors = 0;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_wr_ena", 32'(mem_wr_ena), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    rst = 1'b1;

    run_req(1'b0, 3'b000, 32'h13, 32'h0, lat, e, rd, wn, wc, wd, ix);
    chk("lb13_lat", 32'(lat), 32'd2);
    chk("lb13_err", 32'(e), 32'd0);
    chk("lb13_data", rd, 32'hFFFF_FF88);
    chk("lb13_idx", ix, 32'd4);
    chk("lb13_nowr", 32'(wn), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);

    chk_load("lbu12", 3'b100, 32'h12, 32'h0000_0099);
    chk_load("lh12", 3'b001, 32'h12, 32'hFFFF_8899);
    chk_load("lhu10", 3'b101, 32'h10, 32'h0000_AABB);
    chk_load("lb10", 3'b000, 32'h10, 32'hFFFF_FFBB);
    chk_load("lw10", 3'b010, 32'h10, 32'h8899_AABB);

    run_req(1'b1, 3'b001, 32'h12, 32'h5A5A_1234, lat, e, rd, wn, wc, wd, ix);
    chk("sh12_wr_n", 32'(wn), 32'd1);
    chk("sh12_wr_cyc", 32'(wc), 32'd2);
    chk("sh12_wr_data", wd, 32'h1234_AABB);
    chk("sh12_lat", 32'(lat), 32'd3);
    chk("sh12_err", 32'(e), 32'd0);
    chk("sh12_rdata", rd, 32'h0);
    chk("sh12_ram", ram[4], 32'h1234_AABB);
    chk_load("lw10_after_sh", 3'b010, 32'h10, 32'h1234_AABB);

    chk_err("lw6_misalign", 1'b0, 3'b010, 32'h6, 32'h0);
    chk_err("sh1_misalign", 1'b1, 3'b001, 32'h1, 32'hFFFF);
    chk_err("sw200_range", 1'b1, 3'b010, 32'h200, 32'h1111_1111);
    chk_err("f3_011", 1'b1, 3'b011, 32'h8, 32'h2222_2222);
    chk_err("st_f3_100", 1'b1, 3'b100, 32'h8, 32'h3333_3333);
    chk_err("lw_hi_addr", 1'b0, 3'b010, 32'h8000_0010, 32'h0);
    chk("err_ram0", ram[0], 32'h1000_0000);
    chk("err_ram2", ram[2], 32'h1000_0002);

    // Reset pulse in the middle of the WRITE cycle of a word store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_wena_pre", 32'(mem_wr_ena), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rstw_ready_in_rst", 32'(req_ready), 32'd1);
    chk("rstw_wena_in_rst", 32'(mem_wr_ena), 32'd0);
    chk("rstw_addr_in_rst", 32'(mem_addr), 32'd0);
    #1 rst = 1'b1;
    seen = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("rstw_no_resp", 32'(seen), 32'd0);
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_ram0", ram[0], 32'h1000_0000);

    // Back-to-back: SB then LW to the same word with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h9; req_wdata = 32'hFFFF_FFC3;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h0;
    ready_at = 0; r1 = 0; r2 = 0; d2 = '0; bwc = 0; bwd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (req_ready && ready_at == 0) ready_at = c;
      if (mem_wr_ena) begin
        bwc = c;
        bwd = mem_wr_data;
      end
      if (resp_valid) begin
        if (r1 == 0) r1 = c;
        else if (r2 == 0) begin
          r2 = c;
          d2 = resp_rdata;
        end
      end
      if (c == 5) req_valid = 1'b0;
    end
    chk("b2b_ready_at", 32'(ready_at), 32'd4);
    chk("b2b_wr_cyc", 32'(bwc), 32'd2);
    chk("b2b_wr_data", bwd, 32'h1000_C302);
    chk("b2b_sb_resp", 32'(r1), 32'd3);
    chk("b2b_lw_resp", 32'(r2), 32'd6);
    chk("b2b_lw_data", d2, 32'h1000_C302);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
